// File: rtl/regfile_block_xfer_ctrl.sv
// Load/store-multiple sequencer: walks a 16-bit register list lowest-first, one memory beat per register.
// Optional base-register writeback (wb/base_reg ports, WB state) is built when REGFILE_XFER_WRITEBACK_EN is defined.
module regfile_block_xfer_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic              incr,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base,
`ifdef REGFILE_XFER_WRITEBACK_EN
  input  logic              wb,
  input  logic [3:0]        base_reg,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] final_addr,
  output logic              rf_ld,
  output logic [3:0]        rf_dsel,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        rf_rsel,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

`ifdef REGFILE_XFER_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;
  localparam state_t S_LAST = S_WB;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  localparam state_t S_LAST = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_t            state, state_nxt;
  logic              load_q;
  logic [15:0]       pending, pending_nxt;
  logic [ADDR_W-1:0] addr_q, final_q, span;
  logic [4:0]        list_cnt;
  logic [3:0]        cur;
  logic              rf_ld_q;
  logic [3:0]        rf_dsel_q;
  logic [DATA_W-1:0] rf_wdata_q;
`ifdef REGFILE_XFER_WRITEBACK_EN
  logic              wb_q;
  logic [3:0]        base_reg_q;
`endif

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  always_comb begin
    list_cnt    = popcount16(reg_list);
    span        = STEP * ADDR_W'(list_cnt);
    cur         = lowest_set(pending);
    pending_nxt = pending & ~(16'd1 << cur);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output and next-state gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_rsel    = '0;
    final_addr = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (list_cnt != 5'd0) state_nxt = S_XFER;
`ifdef REGFILE_XFER_WRITEBACK_EN
          else if (wb)          state_nxt = S_WB;
`endif
          else                  state_nxt = S_DONE;
        end
      end
      S_XFER: begin
        busy       = 1'b1;
        mem_req    = 1'b1;
        mem_we     = ~load_q;
        mem_addr   = addr_q;
        rf_rsel    = cur;
        mem_wdata  = load_q ? '0 : rf_rdata;
        final_addr = final_q;
        if (mem_ack && pending_nxt == 16'd0) state_nxt = S_LAST;
      end
`ifdef REGFILE_XFER_WRITEBACK_EN
      S_WB: begin
        busy       = 1'b1;
        final_addr = final_q;
        state_nxt  = S_DONE;
      end
`endif
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        final_addr = final_q;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q     <= 1'b0;
      pending    <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      rf_ld_q    <= 1'b0;
      rf_dsel_q  <= '0;
      rf_wdata_q <= '0;
`ifdef REGFILE_XFER_WRITEBACK_EN
      wb_q       <= 1'b0;
      base_reg_q <= '0;
`endif
    end else begin
      // NOTE: the register-file write port clears every cycle, so a write is a single-cycle pulse and reset drops it.
      rf_ld_q    <= 1'b0;
      rf_dsel_q  <= '0;
      rf_wdata_q <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            load_q  <= load;
            pending <= reg_list;
            addr_q  <= incr ? base : base - span;
            final_q <= incr ? base + span : base - span;
`ifdef REGFILE_XFER_WRITEBACK_EN
            wb_q       <= wb & ~(load & reg_list[base_reg]);
            base_reg_q <= base_reg;
`endif
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            pending <= pending_nxt;
            addr_q  <= addr_q + STEP;
            if (load_q) begin
              rf_ld_q    <= 1'b1;
              rf_dsel_q  <= cur;
              rf_wdata_q <= mem_rdata;
            end
          end
        end
`ifdef REGFILE_XFER_WRITEBACK_EN
        S_WB: begin
          if (wb_q) begin
            rf_ld_q    <= 1'b1;
            rf_dsel_q  <= base_reg_q;
            rf_wdata_q <= DATA_W'(final_q);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign rf_ld    = rf_ld_q;
  assign rf_dsel  = rf_dsel_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_block_xfer_ctrl.sv
// Scoreboard bench for regfile_block_xfer_ctrl: expected beats and register writes are queued at command time
// and popped by a monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_regfile_block_xfer_ctrl;

`ifdef REGFILE_XFER_WRITEBACK_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, load, incr;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic        busy, done, rf_ld, mem_req, mem_we;
  logic [31:0] final_addr, rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_dsel, rf_rsel;
  logic        mem_ack = 1'b0;
`ifdef REGFILE_XFER_WRITEBACK_EN
  logic        wb_i = 1'b0;
  logic [3:0]  base_reg_i = 4'd0;
`endif

  typedef struct packed { logic [31:0] addr; logic we; logic [3:0] rsel; } beat_t;
  typedef struct packed { logic [3:0] dsel; logic [31:0] data; } wr_t;

  beat_t beat_q[$];
  wr_t   wr_q[$];
  beat_t mon_b;
  wr_t   mon_w;
  int    total = 0, bad = 0, done_seen = 0, ack_delay = 0, wait_cnt = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rf_model(input logic [3:0] r);
    return {24'hCAFE00, 4'h0, r};
  endfunction

  assign rf_rdata  = rf_model(rf_rsel);
  assign mem_rdata = mem_model(mem_addr);

  always #5 clk = ~clk;

  regfile_block_xfer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .load(load), .incr(incr),
    .reg_list(reg_list), .base(base),
`ifdef REGFILE_XFER_WRITEBACK_EN
    .wb(wb_i), .base_reg(base_reg_i),
`endif
    .busy(busy), .done(done), .final_addr(final_addr),
    .rf_ld(rf_ld), .rf_dsel(rf_dsel), .rf_wdata(rf_wdata),
    .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory responder: acks each beat after ack_delay idle cycles.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin mem_ack = 1'b1; wait_cnt = 0; end
      else begin mem_ack = 1'b0; wait_cnt++; end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  end

  // Monitor: every cycle a beat is presented it must match the queue head (so address is held while waiting).
  always @(negedge clk) begin
    #1;
    if (done) done_seen++;
    if (mem_req && !reset) begin
      total++;
      if (beat_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: addr=%h we=%b rsel=%0d, required no beat", mem_addr, mem_we, rf_rsel);
      end else begin
        mon_b = beat_q[0];
        if ({mem_addr, mem_we, rf_rsel} !== {mon_b.addr, mon_b.we, mon_b.rsel}) begin
          bad++;
          $display("FAIL beat: got addr=%h we=%b rsel=%0d, required addr=%h we=%b rsel=%0d",
                   mem_addr, mem_we, rf_rsel, mon_b.addr, mon_b.we, mon_b.rsel);
        end
        if (mon_b.we) begin
          total++;
          if (mem_wdata !== rf_model(mon_b.rsel)) begin
            bad++;
            $display("FAIL beat_wdata: got %h, required %h", mem_wdata, rf_model(mon_b.rsel));
          end
        end
        if (mem_ack) void'(beat_q.pop_front());
      end
    end
    if (rf_ld) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL rf_unexpected: dsel=%0d wdata=%h, required no write", rf_dsel, rf_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if ({rf_dsel, rf_wdata} !== {mon_w.dsel, mon_w.data}) begin
          bad++;
          $display("FAIL rf_write: got dsel=%0d wdata=%h, required dsel=%0d wdata=%h",
                   rf_dsel, rf_wdata, mon_w.dsel, mon_w.data);
        end
      end
    end
  end

  // Queue the expected traffic for one command, issue it, and wait (bounded) for done.
  task automatic run_cmd(input string name, input logic ld, input logic inc, input logic [15:0] lst,
                         input logic [31:0] b, input int exp_lat);
    int          n, lat, cycles;
    logic [31:0] a, fin;
    beat_t       bt;
    wr_t         wt;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(lst[i]);
    fin = inc ? b + 32'(4 * n) : b - 32'(4 * n);
    a   = inc ? b : b - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        bt.addr = a; bt.we = ~ld; bt.rsel = 4'(i);
        beat_q.push_back(bt);
        if (ld) begin wt.dsel = 4'(i); wt.data = mem_model(a); wr_q.push_back(wt); end
        a = a + 32'd4;
      end
    end
    lat = exp_lat;
    if (lst != 16'd0) lat += XTRA;
`ifdef REGFILE_XFER_WRITEBACK_EN
    else if (wb_i) lat += 1;
    if (wb_i && !(ld && lst[base_reg_i])) begin
      wt.dsel = base_reg_i; wt.data = fin; wr_q.push_back(wt);
    end
`endif
    @(negedge clk);
    load = ld; incr = inc; reg_list = lst; base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    cycles = 1;
    while (!done && cycles < 300) begin
      @(negedge clk); #1; cycles++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, cycles);
    end else begin
      total++;
      if (cycles != lat) begin
        bad++;
        $display("FAIL %s_latency: done at cycle %0d, required %0d", name, cycles, lat);
      end
      total++;
      if (final_addr !== fin) begin
        bad++;
        $display("FAIL %s_final_addr: got %h, required %h", name, final_addr, fin);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_busy_at_done: got %b, required 1", name, busy);
      end
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || beat_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL %s_end: busy=%b beats_left=%0d writes_left=%0d, required 0/0/0",
               name, busy, beat_q.size(), wr_q.size());
    end
    beat_q.delete();
    wr_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; load = 1'b0; incr = 1'b0; reg_list = '0; base = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, done, rf_ld, mem_req, mem_we, rf_dsel, rf_rsel, rf_wdata, mem_addr, final_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {busy, done, rf_ld, mem_req, mem_we, rf_dsel, rf_rsel, rf_wdata, mem_addr, final_addr});
    end
  endtask

  task automatic test_store();
    ack_delay = 0;
    run_cmd("store", 1'b0, 1'b1, 16'h0015, 32'h100, 4);
    run_cmd("store_dec_wrap", 1'b0, 1'b0, 16'h0007, 32'h4, 4);
  endtask

  task automatic test_load();
    ack_delay = 2;
    run_cmd("load_dec", 1'b1, 1'b0, 16'h8001, 32'h200, 7);
    ack_delay = 0;
    run_cmd("load_all_wrap", 1'b1, 1'b1, 16'hFFFF, 32'hFFFF_FFF0, 17);
  endtask

  task automatic test_empty();
    run_cmd("empty_inc", 1'b0, 1'b1, 16'h0000, 32'h700, 1);
    run_cmd("empty_dec", 1'b1, 1'b0, 16'h0000, 32'h0, 1);
  endtask

  task automatic test_start_ignored();
    beat_t bt;
    wr_t   wt;
    int    cycles;
    ack_delay = 0;
    bt.addr = 32'h500; bt.we = 1'b1; bt.rsel = 4'd0; beat_q.push_back(bt);
    bt.addr = 32'h504; bt.we = 1'b1; bt.rsel = 4'd1; beat_q.push_back(bt);
    @(negedge clk);
    load = 1'b0; incr = 1'b1; reg_list = 16'h0003; base = 32'h500; start = 1'b1;
    @(negedge clk);
    load = 1'b1; incr = 1'b0; reg_list = 16'hFF00; base = 32'h900; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (XTRA) @(negedge clk);
    @(negedge clk);
    load = 1'b1; incr = 1'b1; reg_list = 16'h0F00; base = 32'hA00; start = 1'b1;
    #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL busy_start_done: done=%b, required 1", done);
    end
    @(negedge clk);
    bt.addr = 32'h5FC; bt.we = 1'b0; bt.rsel = 4'd4; beat_q.push_back(bt);
    wt.dsel = 4'd4; wt.data = mem_model(32'h5FC); wr_q.push_back(wt);
    load = 1'b1; incr = 1'b0; reg_list = 16'h0010; base = 32'h600; start = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_after_done_idle: busy=%b, required 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    cycles = 1;
    while (!done && cycles < 50) begin @(negedge clk); #1; cycles++; end
    total++;
    if (done !== 1'b1 || final_addr !== 32'h5FC) begin
      bad++;
      $display("FAIL start_accepted: done=%b final_addr=%h, required 1 and 000005fc", done, final_addr);
    end
    @(negedge clk); #1;
    total++;
    if (beat_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL start_ignored_end: beats_left=%0d writes_left=%0d, required 0/0", beat_q.size(), wr_q.size());
    end
    beat_q.delete();
    wr_q.delete();
  endtask

  task automatic test_reset_abort();
    beat_t bt;
    wr_t   wt;
    int    d0;
    ack_delay = 0;
    bt.addr = 32'h300; bt.we = 1'b0; bt.rsel = 4'd0; beat_q.push_back(bt);
    wt.dsel = 4'd0; wt.data = mem_model(32'h300); wr_q.push_back(wt);
    @(negedge clk);
    load = 1'b1; incr = 1'b1; reg_list = 16'h0003; base = 32'h300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d0 = done_seen;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, done, rf_ld, mem_req, mem_we, rf_dsel, rf_rsel, rf_wdata, mem_addr, final_addr} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got %h, required 0",
               {busy, done, rf_ld, mem_req, mem_we, rf_dsel, rf_rsel, rf_wdata, mem_addr, final_addr});
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (done_seen != d0 || beat_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL abort_residue: done_pulses=%0d beats_left=%0d writes_left=%0d, required 0/0/0",
               done_seen - d0, beat_q.size(), wr_q.size());
    end
    beat_q.delete();
    wr_q.delete();
    run_cmd("after_reset", 1'b1, 1'b1, 16'h0003, 32'h300, 3);
  endtask

`ifdef REGFILE_XFER_WRITEBACK_EN
  task automatic test_writeback();
    ack_delay = 0;
    wb_i = 1'b1; base_reg_i = 4'd3;
    run_cmd("wb_update", 1'b1, 1'b1, 16'h0006, 32'h40, 3);
    run_cmd("wb_loaded_wins", 1'b1, 1'b1, 16'h0008, 32'h40, 2);
    run_cmd("wb_store", 1'b0, 1'b1, 16'h0008, 32'h40, 2);
    run_cmd("wb_empty", 1'b1, 1'b1, 16'h0000, 32'h40, 1);
    wb_i = 1'b0;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_empty();
    test_start_ignored();
    test_reset_abort();
`ifdef REGFILE_XFER_WRITEBACK_EN
    test_writeback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
